// File: rtl/unidad_logica_seq.sv
// Sequential logic unit: single-cycle AND/OR/XOR, and iterative shifts of one bit per clock.
// A start/busy/done handshake drives it; result and flags are registered.
module unidad_logica_seq #(
   parameter int unsigned NUM_BITS = 8,
   localparam int unsigned CNT_BITS = $clog2(NUM_BITS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [NUM_BITS-1:0] A,
   input  logic [NUM_BITS-1:0] B,
   input  logic [2:0]          S,
   output logic [NUM_BITS-1:0] R,
   output logic                Z,
   output logic                N,
   output logic                err,
   output logic                busy,
   output logic                done
);

   localparam logic [NUM_BITS-1:0] NumBitsW = NUM_BITS'(NUM_BITS);
   localparam logic [CNT_BITS-1:0] CntMax   = CNT_BITS'(NUM_BITS);
   localparam logic [CNT_BITS-1:0] CntOne   = CNT_BITS'(1);

   localparam logic [2:0] OpAnd = 3'd0;
   localparam logic [2:0] OpOr  = 3'd1;
   localparam logic [2:0] OpXor = 3'd2;
   localparam logic [2:0] OpLsl = 3'd3;
   localparam logic [2:0] OpLsr = 3'd4;
   localparam logic [2:0] OpAsr = 3'd5;

   typedef enum logic {StIdle, StShift} state_e;

   state_e              state_q;
   logic [NUM_BITS-1:0] work_q;
   logic [CNT_BITS-1:0] cnt_q;
   logic [2:0]          op_q;
   logic [NUM_BITS-1:0] r_q;
   logic                z_q, n_q, err_q, busy_q, done_q;

   logic [CNT_BITS-1:0] amt;
   logic [NUM_BITS-1:0] shifted;
   logic                fin, fin_err, go_shift;
   logic [NUM_BITS-1:0] fin_val;

   // Clamp the shift amount so oversized B costs exactly NUM_BITS cycles.
   always_comb begin
      amt = (B >= NumBitsW) ? CntMax : B[CNT_BITS-1:0];
   end

   // One-bit step of the working register for the captured shift kind.
   always_comb begin
      unique case (op_q)
         OpLsl:   shifted = {work_q[NUM_BITS-2:0], 1'b0};
         OpLsr:   shifted = {1'b0, work_q[NUM_BITS-1:1]};
         default: shifted = {work_q[NUM_BITS-1], work_q[NUM_BITS-1:1]};
      endcase
   end

   // Decide whether this edge completes an operation or launches a shift.
   always_comb begin
      fin      = 1'b0;
      fin_err  = 1'b0;
      fin_val  = '0;
      go_shift = 1'b0;
      if (state_q == StShift) begin
         if (cnt_q == CntOne) begin
            fin     = 1'b1;
            fin_val = shifted;
         end
      end else if (start) begin
         unique case (S)
            OpAnd: begin fin = 1'b1; fin_val = A & B; end
            OpOr:  begin fin = 1'b1; fin_val = A | B; end
            OpXor: begin fin = 1'b1; fin_val = A ^ B; end
            OpLsl, OpLsr, OpAsr: begin
               if (amt == '0) begin
                  fin     = 1'b1;
                  fin_val = A;
               end else begin
                  go_shift = 1'b1;
               end
            end
            default: begin fin = 1'b1; fin_err = 1'b1; end
         endcase
      end
   end

   // FSM with registered result, flags and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         work_q  <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         r_q     <= '0;
         z_q     <= 1'b1;
         n_q     <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= fin;
         if (fin) begin
            r_q   <= fin_val;
            z_q   <= (fin_val == '0);
            n_q   <= fin_val[NUM_BITS-1];
            err_q <= fin_err;
         end
         unique case (state_q)
            StIdle: begin
               if (go_shift) begin
                  work_q  <= A;
                  cnt_q   <= amt;
                  op_q    <= S;
                  busy_q  <= 1'b1;
                  state_q <= StShift;
               end
            end
            StShift: begin
               work_q <= shifted;
               cnt_q  <= cnt_q - CntOne;
               if (fin) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign R    = r_q;
   assign Z    = z_q;
   assign N    = n_q;
   assign err  = err_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_unidad_logica_seq.sv
// Bench for unidad_logica_seq: directed cases with literal expectations plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_unidad_logica_seq;

   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [NB-1:0] A, B, R;
   logic [2:0]    S;
   logic          Z, N, err, busy, done;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model state: pending result and remaining edges of an in-flight shift.
   int            m_rem;
   logic [NB-1:0] m_pend, m_r;
   logic          m_z, m_n, m_err, m_busy, m_done;

   unidad_logica_seq #(.NUM_BITS(NB)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .S     (S),
      .R     (R),
      .Z     (Z),
      .N     (N),
      .err   (err),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic int amount(input logic [NB-1:0] b);
      return (int'(b) > NB) ? NB : int'(b);
   endfunction

   function automatic logic [NB-1:0] ref_result(input logic [2:0] s, input logic [NB-1:0] a,
                                                input logic [NB-1:0] b);
      int n;
      n = amount(b);
      case (s)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return a << n;
         3'd4:    return a >> n;
         3'd5:    return NB'($signed(a) >>> n);
         default: return '0;
      endcase
   endfunction

   // Transaction-level reference: result known at accept, released after n+1 edges.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem  <= 0;
         m_pend <= '0;
         m_r    <= '0;
         m_z    <= 1'b1;
         m_n    <= 1'b0;
         m_err  <= 1'b0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_r    <= m_pend;
               m_z    <= (m_pend == '0);
               m_n    <= m_pend[NB-1];
               m_err  <= 1'b0;
               m_done <= 1'b1;
               m_busy <= 1'b0;
            end
         end else if (start) begin
            if (S >= 3'd3 && S <= 3'd5 && amount(B) > 0) begin
               m_rem  <= amount(B);
               m_busy <= 1'b1;
               m_pend <= ref_result(S, A, B);
            end else begin
               m_r    <= ref_result(S, A, B);
               m_z    <= (ref_result(S, A, B) == '0);
               m_n    <= ref_result(S, A, B) >> (NB - 1) != 0;
               m_err  <= (S > 3'd5);
               m_done <= 1'b1;
            end
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("done", done, m_done);
         chk("busy", busy, m_busy);
         chk("R", R, m_r);
         chk("Z", Z, m_z);
         chk("N", N, m_n);
         chk("err", err, m_err);
      end
   end

   // Issue one op, pulse start and scramble A while busy; report latency and busy cycles.
   task automatic run_op(input logic [2:0] s, input logic [NB-1:0] a, input logic [NB-1:0] b,
                         output int lat, output int bc);
      int cyc;
      start = 1'b1;
      S = s;
      A = a;
      B = b;
      bc = 0;
      cyc = 1;
      @(negedge clk);
      while (!done && cyc < 40) begin
         if (busy) begin
            bc++;
            start = 1'b1;
            A = NB'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      lat = cyc;
      chk("done_seen", done, 1'b1);
   endtask

   initial begin
      int lat, bc;
      rst = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      S = '0;
      #12;
      chk("rst_R", R, 8'h00);
      chk("rst_Z", Z, 1'b1);
      chk("rst_N", N, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Single-cycle AND.
      run_op(3'd0, 8'hF0, 8'h3C, lat, bc);
      chk("t1_lat", lat, 1);
      chk("t1_busy", bc, 0);
      chk("t1_R", R, 8'h30);
      chk("t1_Z", Z, 1'b0);
      chk("t1_N", N, 1'b0);

      // Back-to-back OR then XOR.
      start = 1'b1; S = 3'd1; A = 8'h0F; B = 8'hF0;
      @(negedge clk);
      chk("t2a_done", done, 1'b1);
      chk("t2a_R", R, 8'hFF);
      chk("t2a_N", N, 1'b1);
      S = 3'd2; A = 8'hAA; B = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      chk("t2b_done", done, 1'b1);
      chk("t2b_R", R, 8'h00);
      chk("t2b_Z", Z, 1'b1);

      // ASR by 3 with start pulses and A changes while busy.
      run_op(3'd5, 8'h90, 8'd3, lat, bc);
      chk("t3_busy", bc, 3);
      chk("t3_lat", lat, 4);
      chk("t3_R", R, 8'hF2);
      chk("t3_N", N, 1'b1);

      // Zero-length shift, then clamped LSR.
      run_op(3'd3, 8'h81, 8'd0, lat, bc);
      chk("t4a_lat", lat, 1);
      chk("t4a_R", R, 8'h81);
      run_op(3'd4, 8'h81, 8'd200, lat, bc);
      chk("t4b_busy", bc, 8);
      chk("t4b_R", R, 8'h00);
      chk("t4b_Z", Z, 1'b1);

      // Invalid opcode, then a valid op clears err.
      run_op(3'd6, 8'hFF, 8'hFF, lat, bc);
      chk("t5a_R", R, 8'h00);
      chk("t5a_err", err, 1'b1);
      chk("t5a_Z", Z, 1'b1);
      run_op(3'd0, 8'hFF, 8'h01, lat, bc);
      chk("t5b_err", err, 1'b0);
      chk("t5b_R", R, 8'h01);

      // Asynchronous reset during a shift.
      start = 1'b1; S = 3'd3; A = 8'h01; B = 8'd5;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_R", R, 8'h00);
      chk("t6_Z", Z, 1'b1);
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      run_op(3'd3, 8'h01, 8'd1, lat, bc);
      chk("t6b_lat", lat, 2);
      chk("t6b_R", R, 8'h02);

      // Random traffic against the model, with one asynchronous reset mid-run.
      for (int i = 0; i < 400; i++) begin
         start = 1'($urandom_range(0, 1));
         S = 3'($urandom_range(0, 7));
         A = NB'($urandom);
         B = ($urandom_range(0, 3) == 0) ? NB'($urandom) : NB'($urandom_range(0, 9));
         if (i == 200) begin
            #3 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
